stack_sequencer: RTL and testbench
==================================

// Module: stack_sequencer
// PURPOSE
//  Initiator side of the stack interface. Turns CALL/RET/PUSH/POP/INT/RETI requests from decode into
//  push/pop pulse sequences for stack_unit, and collects popped data into PC/flag/register updates.
//  Sits between the decoder/PC logic and stack_unit. Guards against full/empty stacks and reports sticky faults.
// PARAMETERS
//  ADDR_W       8      width of return addresses, stack data and result_data
//  FLAG_W       4      flag bits pushed by INT and restored by RETI (zero-extended to ADDR_W on the stack)
//  INT_VECTOR   8'h04  PC target for INT
//  POP_TIMEOUT  4      max cycles in POP_WAIT without stk_valid before a timeout fault (>=1)
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous reset, active-high
//  req_valid    in   1       request offered
//  req_ready    out  1       request accepted when req_valid&req_ready
//  req_op       in   3       0 NOP,1 CALL,2 RET,3 PUSH,4 POP,5 INT,6 RETI,7 illegal(=NOP)
//  req_pc       in   ADDR_W  return address for CALL/INT (caller supplies PC+1)
//  req_data     in   ADDR_W  CALL target / PUSH data
//  flags_in     in   FLAG_W  current flags, pushed by INT
//  push_en      out  1       to stack_unit push_enable
//  pop_en       out  1       to stack_unit pop_enable
//  push_data    out  ADDR_W  to stack_unit push_data
//  stk_data     in   ADDR_W  from stack_unit pop_data
//  stk_valid    in   1       from stack_unit stack_valid
//  stk_full     in   1       from stack_unit stack_full
//  stk_empty    in   1       from stack_unit stack_empty
//  pc_load      out  1       one-cycle pulse: load pc_target into PC
//  pc_target    out  ADDR_W  new PC
//  flags_load   out  1       one-cycle pulse: load flags_out
//  flags_out    out  FLAG_W  restored flags (low FLAG_W bits of popped word)
//  result_valid out  1       one-cycle pulse: result_data holds POP value
//  result_data  out  ADDR_W  popped value for POP
//  done         out  1       one-cycle pulse: request completed without fault
//  fault        out  1       sticky fault flag
//  fault_code   out  2       1 overflow, 2 underflow, 3 pop timeout
//  fault_clr    in   1       clears fault/fault_code, returns to IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (req_ready 0 while rst high, 1 in the first cycle after release).
//  req_ready = (state==IDLE) && !fault. Only one request in flight; no request queueing.
//  States: IDLE, PUSH_A, PUSH_B, POP_A, WAIT_A, POP_B, WAIT_B, FIN, FAULT.
//  push_en = (PUSH_A|PUSH_B) & !stk_full; pop_en = (POP_A|POP_B) & !stk_empty (combinational on state+flags).
//  Full in a PUSH state, or empty in a POP state: no pulse issued; go to FAULT, code 1 or 2.
//  CALL: c0 accept; c1 PUSH_A push_data=req_pc; c2 FIN pc_load=1, pc_target=req_data, done=1.
//  PUSH: same as CALL, push_data=req_data, no pc_load. NOP/illegal: c1 FIN, done=1 only.
//  INT: c1 PUSH_A push {0,flags_in}; c2 PUSH_B push req_pc; c3 FIN pc_load=1, pc_target=INT_VECTOR.
//  RET: c1 POP_A pop_en; WAIT_A captures stk_data on stk_valid (normally c2);
//    next cycle FIN pc_load=1, pc_target=captured value.
//  POP: as RET, but FIN drives result_valid=1 and result_data instead of pc_load.
//  RETI: POP_A/WAIT_A capture address, then POP_B/WAIT_B capture flags;
//    FIN pc_load=1 and flags_load=1 in the same cycle.
//  WAIT counter: counts cycles in a WAIT state; after POP_TIMEOUT cycles without stk_valid go to FAULT, code 3.
//  stk_valid outside a WAIT state is ignored.
//  req_* and flags_in are latched at accept; later changes have no effect.
//  FIN lasts one cycle, then returns to IDLE; done=1 only in FIN.
//  FAULT: fault=1 and no pc_load/flags_load/result_valid. Completed stack ops are not rolled back:
//    an INT faulting on PUSH_B leaves the flags word pushed.
//  fault_clr in FAULT: next cycle IDLE, fault=0, fault_code=0. In other states fault_clr is ignored.
//  Async reset mid-sequence: immediate IDLE, pulses drop the same cycle; stack content already written is kept.
//  pc_target/result_data/flags_out hold their last value between pulses.
// TESTING
//  CALL req_pc=8'h11 req_data=8'h40 -> c1 push_en,push_data=11; c2 pc_load,pc_target=40,done; then RET -> pc_target=11.
//  INT flags_in=4'b1010 req_pc=8'h23 -> pushes 0A then 23; pc_target=04; RETI -> pc_target=23, flags_out=1010, both loads same cycle.
//  PUSH with stk_full=1 -> push_en never 1; fault=1, code=1; req_ready=0 until fault_clr, then 1 next cycle.
//  POP with stk_empty=1 -> pop_en never 1; fault code=2, no result_valid. PUSH 8'h5A then POP -> result_data=5A.
//  RET with stk_valid held low -> after POP_TIMEOUT=4 wait cycles fault code=3; a late stk_valid is ignored.
//  Assert rst during INT PUSH_B -> push_en drops immediately, all outputs 0, one word left on the stack, req_ready=1 after release.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// ============================================================================
// Module   : stack_sequencer_if
// Brief    : Request, stack-unit and result signals of the stack sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int FLAG_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_data;
  logic [FLAG_W-1:0] flags_in;
  logic              push_en;
  logic              pop_en;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] stk_data;
  logic              stk_valid;
  logic              stk_full;
  logic              stk_empty;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              flags_load;
  logic [FLAG_W-1:0] flags_out;
  logic              result_valid;
  logic [ADDR_W-1:0] result_data;
  logic              done;
  logic              fault;
  logic [1:0]        fault_code;
  logic              fault_clr;

  // Master: decoder plus stack unit side; slave: the sequencer itself.
  modport master (
    output req_valid, req_op, req_pc, req_data, flags_in,
           stk_data, stk_valid, stk_full, stk_empty, fault_clr,
    input  req_ready, push_en, pop_en, push_data, pc_load, pc_target,
           flags_load, flags_out, result_valid, result_data, done, fault, fault_code
  );

  modport slave (
    input  req_valid, req_op, req_pc, req_data, flags_in,
           stk_data, stk_valid, stk_full, stk_empty, fault_clr,
    output req_ready, push_en, pop_en, push_data, pc_load, pc_target,
           flags_load, flags_out, result_valid, result_data, done, fault, fault_code
  );
endinterface

`default_nettype wire

// File: rtl/stack_sequencer.sv
// ============================================================================
// Module   : stack_sequencer
// Brief    : Turns CALL/RET/PUSH/POP/INT/RETI requests into stack push/pop
//            pulse sequences and collects popped words into PC/flag/result updates.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                FLAG_W      = 4,
  parameter logic [ADDR_W-1:0] INT_VECTOR  = 8'h04,
  parameter int                POP_TIMEOUT = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  stack_sequencer_if.slave   bus
);

  localparam logic [2:0] c_OP_CALL = 3'd1;
  localparam logic [2:0] c_OP_RET  = 3'd2;
  localparam logic [2:0] c_OP_PUSH = 3'd3;
  localparam logic [2:0] c_OP_POP  = 3'd4;
  localparam logic [2:0] c_OP_INT  = 3'd5;
  localparam logic [2:0] c_OP_RETI = 3'd6;
  localparam int         c_CNT_W   = $clog2(POP_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(POP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_A, S_PUSH_B, S_POP_A, S_WAIT_A, S_POP_B, S_WAIT_B, S_FIN, S_FAULT
  } state_t;

  state_t              r_state;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_data;
  logic [FLAG_W-1:0]   r_flags;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_pc_load;
  logic [ADDR_W-1:0]   r_pc_target;
  logic                r_flags_load;
  logic [FLAG_W-1:0]   r_flags_out;
  logic                r_result_valid;
  logic [ADDR_W-1:0]   r_result_data;
  logic                r_done;
  logic                r_fault;
  logic [1:0]          r_fault_code;

  logic                w_ready;
  logic                w_push_state;
  logic                w_pop_state;
  logic [ADDR_W-1:0]   w_first_word;

  // rst is folded in so the request port stays closed while reset is held.
  assign w_ready      = (r_state == S_IDLE) && !r_fault && !rst;
  assign w_push_state = (r_state == S_PUSH_A) || (r_state == S_PUSH_B);
  assign w_pop_state  = (r_state == S_POP_A)  || (r_state == S_POP_B);
  assign w_first_word = (r_op == c_OP_INT)  ? ADDR_W'(r_flags) :
                        (r_op == c_OP_CALL) ? r_pc : r_data;

  assign bus.req_ready    = w_ready;
  assign bus.push_en      = w_push_state && !bus.stk_full;
  assign bus.pop_en       = w_pop_state && !bus.stk_empty;
  assign bus.push_data    = !w_push_state ? '0 : (r_state == S_PUSH_B) ? r_pc : w_first_word;
  assign bus.pc_load      = r_pc_load;
  assign bus.pc_target    = r_pc_target;
  assign bus.flags_load   = r_flags_load;
  assign bus.flags_out    = r_flags_out;
  assign bus.result_valid = r_result_valid;
  assign bus.result_data  = r_result_data;
  assign bus.done         = r_done;
  assign bus.fault        = r_fault;
  assign bus.fault_code   = r_fault_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_pc           <= '0;
      r_data         <= '0;
      r_flags        <= '0;
      r_addr         <= '0;
      r_cnt          <= '0;
      r_pc_load      <= 1'b0;
      r_pc_target    <= '0;
      r_flags_load   <= 1'b0;
      r_flags_out    <= '0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
      r_fault_code   <= '0;
    end else begin
      r_pc_load      <= 1'b0;
      r_flags_load   <= 1'b0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && w_ready) begin
            r_op    <= bus.req_op;
            r_pc    <= bus.req_pc;
            r_data  <= bus.req_data;
            r_flags <= bus.flags_in;
            case (bus.req_op)
              c_OP_CALL, c_OP_PUSH, c_OP_INT: r_state <= S_PUSH_A;
              c_OP_RET,  c_OP_POP,  c_OP_RETI: r_state <= S_POP_A;
              default: begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
              end
            endcase
          end
        end
        S_PUSH_A: begin
          if (bus.stk_full) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= 2'd1;
          end else if (r_op == c_OP_INT) begin
            r_state <= S_PUSH_B;
          end else begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            if (r_op == c_OP_CALL) begin
              r_pc_load   <= 1'b1;
              r_pc_target <= r_data;
            end
          end
        end
        S_PUSH_B: begin
          if (bus.stk_full) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= 2'd1;
          end else begin
            r_state     <= S_FIN;
            r_done      <= 1'b1;
            r_pc_load   <= 1'b1;
            r_pc_target <= INT_VECTOR;
          end
        end
        S_POP_A, S_POP_B: begin
          if (bus.stk_empty) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= 2'd2;
          end else begin
            r_state <= (r_state == S_POP_A) ? S_WAIT_A : S_WAIT_B;
            r_cnt   <= '0;
          end
        end
        S_WAIT_A, S_WAIT_B: begin
          if (bus.stk_valid) begin
            if (r_state == S_WAIT_B) begin
              // Second word of RETI: address was captured from the first pop.
              r_state      <= S_FIN;
              r_done       <= 1'b1;
              r_pc_load    <= 1'b1;
              r_pc_target  <= r_addr;
              r_flags_load <= 1'b1;
              r_flags_out  <= bus.stk_data[FLAG_W-1:0];
            end else if (r_op == c_OP_RETI) begin
              r_addr  <= bus.stk_data;
              r_state <= S_POP_B;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              if (r_op == c_OP_RET) begin
                r_pc_load   <= 1'b1;
                r_pc_target <= bus.stk_data;
              end else begin
                r_result_valid <= 1'b1;
                r_result_data  <= bus.stk_data;
              end
            end
          end else if (r_cnt == c_CNT_LAST) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_code <= 2'd3;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIN: r_state <= S_IDLE;
        S_FAULT: begin
          if (bus.fault_clr) begin
            r_state      <= S_IDLE;
            r_fault      <= 1'b0;
            r_fault_code <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_sequencer.sv
// ============================================================================
// Module   : tb_stack_sequencer
// Brief    : Self-checking bench for stack_sequencer with a stack-unit model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stack_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_sequencer_if #(.ADDR_W(8), .FLAG_W(4)) bus();

  stack_sequencer #(.ADDR_W(8), .FLAG_W(4), .INT_VECTOR(8'h04), .POP_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stack unit model: LIFO, pop data returned one cycle after pop_en.
  logic [7:0] env_q[$];
  int         env_cnt     = 0;
  logic       env_valid   = 1'b0;
  logic [7:0] env_data    = 8'h00;
  bit         force_full  = 1'b0;
  bit         force_empty = 1'b0;
  bit         hold_valid  = 1'b0;
  bit         inject_valid = 1'b0;

  assign bus.stk_full  = force_full || (env_cnt >= DEPTH);
  assign bus.stk_empty = force_empty || (env_cnt == 0);
  assign bus.stk_valid = env_valid;
  assign bus.stk_data  = env_data;

  always @(posedge clk) begin
    env_valid <= inject_valid;
    if (bus.push_en) env_q.push_back(bus.push_data);
    if (bus.pop_en && env_q.size() > 0) begin
      env_data <= env_q.pop_back();
      if (!hold_valid) env_valid <= 1'b1;
    end
    env_cnt <= env_q.size();
  end

  typedef struct {
    bit              tmo;
    bit              done;
    bit              fault;
    logic [1:0]      code;
    int              lat;
    bit              pcl;
    bit              fl;
    bit              rv;
    logic [7:0]      pct;
    logic [7:0]      rd;
    logic [3:0]      flo;
    int              npush;
    int              npop;
    int              stray;
    logic [3:0][7:0] pushed;
  } obs_t;

  // Issue one request and observe until done or fault; ends on a negedge.
  task automatic run_req(input logic [2:0] op, input logic [7:0] pc, input logic [7:0] data,
                         input logic [3:0] fl, output obs_t o);
    int w = 0;
    o.tmo = 0; o.done = 0; o.fault = 0; o.code = 0; o.lat = 0; o.pcl = 0; o.fl = 0; o.rv = 0;
    o.pct = 0; o.rd = 0; o.flo = 0; o.npush = 0; o.npop = 0; o.stray = 0; o.pushed = '0;
    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.req_ready) begin o.tmo = 1; return; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_pc = pc; bus.req_data = data; bus.flags_in = fl;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom); bus.req_pc = 8'($urandom);
    bus.req_data = 8'($urandom); bus.flags_in = 4'($urandom);
    for (int k = 1; k <= 30; k++) begin
      if (bus.push_en) begin
        if (o.npush < 4) o.pushed[o.npush] = bus.push_data;
        o.npush++;
      end
      if (bus.pop_en) o.npop++;
      if (bus.done || bus.fault) begin
        o.done = bus.done; o.fault = bus.fault; o.code = bus.fault_code; o.lat = k;
        o.pcl = bus.pc_load; o.fl = bus.flags_load; o.rv = bus.result_valid;
        o.pct = bus.pc_target; o.rd = bus.result_data; o.flo = bus.flags_out;
        return;
      end
      if (bus.pc_load || bus.flags_load || bus.result_valid) o.stray++;
      @(negedge clk);
    end
    o.tmo = 1;
  endtask

  task automatic do_clear();
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.push_en, bus.pop_en, bus.push_data, bus.pc_load, bus.pc_target,
         bus.flags_load, bus.flags_out, bus.result_valid, bus.result_data, bus.done,
         bus.fault, bus.fault_code} !== 38'd0) begin
      n_errors++; $display("FAIL reset_outputs: some output nonzero during reset (ready=%b done=%b fault=%b)",
                           bus.req_ready, bus.done, bus.fault);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    @(negedge clk);
  endtask

  task automatic test_call_ret();
    obs_t o;
    run_req(3'd1, 8'h11, 8'h40, 4'h0, o);
    n_checks++;
    if (o.tmo || o.npush !== 1 || o.pushed[0] !== 8'h11) begin
      n_errors++; $display("FAIL call_push: npush=%0d word=%h tmo=%b want 1 word 11", o.npush, o.pushed[0], o.tmo);
    end
    n_checks++;
    if (!(o.done && o.pcl && o.pct === 8'h40 && o.lat == 2)) begin
      n_errors++; $display("FAIL call_fin: done=%b pcl=%b pct=%h lat=%0d want 1 1 40 2", o.done, o.pcl, o.pct, o.lat);
    end
    run_req(3'd2, 8'h99, 8'h77, 4'h0, o);
    n_checks++;
    if (!(o.done && o.pcl && o.pct === 8'h11 && o.lat == 3 && o.npop == 1)) begin
      n_errors++; $display("FAIL ret_fin: done=%b pcl=%b pct=%h lat=%0d want 1 1 11 3", o.done, o.pcl, o.pct, o.lat);
    end
  endtask

  task automatic test_int_reti();
    obs_t o;
    run_req(3'd5, 8'h23, 8'h55, 4'b1010, o);
    n_checks++;
    if (o.npush !== 2 || o.pushed[0] !== 8'h0A || o.pushed[1] !== 8'h23) begin
      n_errors++; $display("FAIL int_push: n=%0d w0=%h w1=%h want 2 0a 23", o.npush, o.pushed[0], o.pushed[1]);
    end
    n_checks++;
    if (!(o.done && o.pcl && o.pct === 8'h04 && o.lat == 3)) begin
      n_errors++; $display("FAIL int_fin: done=%b pct=%h lat=%0d want 1 04 3", o.done, o.pct, o.lat);
    end
    run_req(3'd6, 8'h00, 8'h00, 4'h0, o);
    n_checks++;
    if (!(o.done && o.pcl && o.fl && o.pct === 8'h23 && o.flo === 4'b1010 && o.lat == 5 && o.stray == 0)) begin
      n_errors++; $display("FAIL reti_fin: pcl=%b fl=%b pct=%h flo=%b lat=%0d want 1 1 23 1010 5",
                           o.pcl, o.fl, o.pct, o.flo, o.lat);
    end
  endtask

  task automatic test_push_full();
    obs_t o;
    bit   rdy_seen = 0;
    force_full = 1'b1;
    run_req(3'd3, 8'h00, 8'h77, 4'h0, o);
    n_checks++;
    if (!(o.npush == 0 && o.fault && o.code === 2'd1 && !o.done)) begin
      n_errors++; $display("FAIL full_fault: npush=%0d fault=%b code=%0d want 0 1 1", o.npush, o.fault, o.code);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.req_ready) rdy_seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (rdy_seen) begin n_errors++; $display("FAIL full_ready_hold: got ready=1 want 0 while faulted"); end
    force_full = 1'b0;
    do_clear();
    n_checks++;
    if (!(bus.fault === 1'b0 && bus.fault_code === 2'd0 && bus.req_ready === 1'b1)) begin
      n_errors++; $display("FAIL full_clear: fault=%b code=%0d ready=%b want 0 0 1", bus.fault, bus.fault_code, bus.req_ready);
    end
  endtask

  task automatic test_pop_empty();
    obs_t o;
    force_empty = 1'b1;
    run_req(3'd4, 8'h00, 8'h00, 4'h0, o);
    n_checks++;
    if (!(o.npop == 0 && o.fault && o.code === 2'd2 && !o.rv && o.stray == 0)) begin
      n_errors++; $display("FAIL empty_fault: npop=%0d fault=%b code=%0d rv=%b want 0 1 2 0", o.npop, o.fault, o.code, o.rv);
    end
    force_empty = 1'b0;
    do_clear();
  endtask

  task automatic test_push_pop();
    obs_t o;
    run_req(3'd3, 8'h12, 8'h5A, 4'h0, o);
    n_checks++;
    if (!(o.done && !o.pcl && o.npush == 1 && o.pushed[0] === 8'h5A)) begin
      n_errors++; $display("FAIL push_5a: done=%b pcl=%b word=%h want 1 0 5a", o.done, o.pcl, o.pushed[0]);
    end
    run_req(3'd4, 8'h00, 8'h00, 4'h0, o);
    n_checks++;
    if (!(o.done && o.rv && !o.pcl && o.rd === 8'h5A && o.lat == 3)) begin
      n_errors++; $display("FAIL pop_5a: rv=%b pcl=%b rd=%h lat=%0d want 1 0 5a 3", o.rv, o.pcl, o.rd, o.lat);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_req(3'd3, 8'h00, 8'h66, 4'h0, o);
    hold_valid = 1'b1;
    run_req(3'd2, 8'h00, 8'h00, 4'h0, o);
    n_checks++;
    if (!(o.fault && o.code === 2'd3 && o.lat == 6 && o.npop == 1 && !o.pcl)) begin
      n_errors++; $display("FAIL timeout_fault: fault=%b code=%0d lat=%0d want 1 3 6", o.fault, o.code, o.lat);
    end
    inject_valid = 1'b1;
    @(negedge clk);
    inject_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!(bus.fault === 1'b1 && bus.fault_code === 2'd3 && bus.pc_load === 1'b0 && bus.done === 1'b0)) begin
      n_errors++; $display("FAIL late_valid: fault=%b code=%0d pcl=%b want 1 3 0", bus.fault, bus.fault_code, bus.pc_load);
    end
    hold_valid = 1'b0;
    do_clear();
  endtask

  task automatic test_reset_mid();
    int sz;
    sz = env_q.size();
    bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.req_pc = 8'h23; bus.flags_in = 4'b1010;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!(bus.push_en === 1'b1 && bus.push_data === 8'h23)) begin
      n_errors++; $display("FAIL mid_push_b: push_en=%b data=%h want 1 23", bus.push_en, bus.push_data);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.push_en, bus.pop_en, bus.push_data, bus.pc_load, bus.pc_target,
         bus.flags_load, bus.flags_out, bus.result_valid, bus.result_data, bus.done,
         bus.fault, bus.fault_code} !== 38'd0) begin
      n_errors++; $display("FAIL mid_reset_outputs: push_en=%b ready=%b want all 0", bus.push_en, bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || env_q.size() != sz + 1 || env_q[$] !== 8'h0A) begin
      n_errors++; $display("FAIL mid_release: ready=%b stack_size=%0d want 1 %0d", bus.req_ready, env_q.size(), sz + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ref_q[$];
    obs_t o;
    logic [2:0] op;
    logic [7:0] pc, data, a, f;
    logic [3:0] fl;
    bit e_done, e_pcl, e_fl, e_rv, ok;
    logic [1:0] e_code;
    int e_lat, e_np;
    logic [7:0] e_pct, e_rd;
    logic [3:0] e_flo;
    logic [3:0][7:0] e_push;
    ref_q = env_q;
    for (int it = 0; it < 80; it++) begin
      op = 3'($urandom_range(0, 7)); pc = 8'($urandom); data = 8'($urandom); fl = 4'($urandom);
      e_done = 1; e_pcl = 0; e_fl = 0; e_rv = 0; e_code = 0; e_lat = 1; e_np = 0;
      e_pct = 0; e_rd = 0; e_flo = 0; e_push = '0;
      case (op)
        3'd1, 3'd3: begin
          e_lat = 2;
          if (ref_q.size() >= DEPTH) begin e_done = 0; e_code = 1; end
          else begin
            e_push[0] = (op == 3'd1) ? pc : data; e_np = 1; ref_q.push_back(e_push[0]);
            if (op == 3'd1) begin e_pcl = 1; e_pct = data; end
          end
        end
        3'd5: begin
          if (ref_q.size() >= DEPTH) begin e_done = 0; e_code = 1; e_lat = 2; end
          else begin
            e_push[0] = {4'h0, fl}; e_np = 1; ref_q.push_back(e_push[0]); e_lat = 3;
            if (ref_q.size() >= DEPTH) begin e_done = 0; e_code = 1; end
            else begin e_push[1] = pc; e_np = 2; ref_q.push_back(pc); e_pcl = 1; e_pct = 8'h04; end
          end
        end
        3'd2, 3'd4: begin
          if (ref_q.size() == 0) begin e_done = 0; e_code = 2; e_lat = 2; end
          else begin
            a = ref_q.pop_back(); e_lat = 3;
            if (op == 3'd2) begin e_pcl = 1; e_pct = a; end else begin e_rv = 1; e_rd = a; end
          end
        end
        3'd6: begin
          if (ref_q.size() == 0) begin e_done = 0; e_code = 2; e_lat = 2; end
          else begin
            a = ref_q.pop_back();
            if (ref_q.size() == 0) begin e_done = 0; e_code = 2; e_lat = 4; end
            else begin
              f = ref_q.pop_back(); e_lat = 5;
              e_pcl = 1; e_pct = a; e_fl = 1; e_flo = f[3:0];
            end
          end
        end
        default: ;
      endcase
      run_req(op, pc, data, fl, o);
      n_checks++;
      if (o.tmo || o.done !== e_done || o.fault !== !e_done || o.code !== e_code || o.lat != e_lat) begin
        n_errors++; $display("FAIL rnd_status it=%0d op=%0d: done=%b code=%0d lat=%0d tmo=%b want done=%b code=%0d lat=%0d",
                             it, op, o.done, o.code, o.lat, o.tmo, e_done, e_code, e_lat);
      end
      ok = (o.npush == e_np);
      for (int i = 0; i < e_np; i++) if (o.pushed[i] !== e_push[i]) ok = 0;
      n_checks++;
      if (!ok) begin
        n_errors++; $display("FAIL rnd_push it=%0d op=%0d: n=%0d words=%h want n=%0d words=%h",
                             it, op, o.npush, o.pushed, e_np, e_push);
      end
      n_checks++;
      if (o.pcl !== e_pcl || o.fl !== e_fl || o.rv !== e_rv || o.stray != 0 ||
          (e_pcl && o.pct !== e_pct) || (e_fl && o.flo !== e_flo) || (e_rv && o.rd !== e_rd)) begin
        n_errors++; $display("FAIL rnd_result it=%0d op=%0d: pcl=%b pct=%h fl=%b flo=%h rv=%b rd=%h want %b %h %b %h %b %h",
                             it, op, o.pcl, o.pct, o.fl, o.flo, o.rv, o.rd, e_pcl, e_pct, e_fl, e_flo, e_rv, e_rd);
      end
      if (o.fault) begin
        do_clear();
        n_checks++;
        if (bus.fault !== 1'b0 || bus.req_ready !== 1'b1) begin
          n_errors++; $display("FAIL rnd_clear it=%0d: fault=%b ready=%b want 0 1", it, bus.fault, bus.req_ready);
        end
      end
    end
    n_checks++;
    if (env_q != ref_q) begin
      n_errors++; $display("FAIL rnd_stack_contents: size=%0d want %0d", env_q.size(), ref_q.size());
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_pc = 8'h00; bus.req_data = 8'h00;
    bus.flags_in = 4'h0; bus.fault_clr = 1'b0;
    test_reset();
    test_call_ret();
    test_int_reti();
    test_push_full();
    test_pop_empty();
    test_push_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
